// File: rtl/spi_channel_scanner_if.sv
// Bundles the sequencer's remap-file, sensor SPI and host capture signals.
// master: the scanner itself; slave: the surrounding remap file, sensor and host.
interface spi_channel_scanner_if;
  logic        start;
  logic        continuous;
  logic [6:0]  Index_number;
  logic [6:0]  Index_number_remapped;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] sample_data;
  logic [6:0]  sample_index;
  logic        sample_valid;
  logic        busy;
  logic        scan_done;

  modport master (
    input  start, continuous, Index_number_remapped, spi_miso,
    output Index_number, spi_cs_n, spi_sclk, spi_mosi,
           sample_data, sample_index, sample_valid, busy, scan_done
  );

  modport slave (
    output start, continuous, Index_number_remapped, spi_miso,
    input  Index_number, spi_cs_n, spi_sclk, spi_mosi,
           sample_data, sample_index, sample_valid, busy, scan_done
  );
endinterface

// File: rtl/spi_channel_scanner.sv
// Walks logical channels through the remap file and runs one 24-bit SPI read
// frame per channel, handing each 16-bit sample to host capture logic.
module spi_channel_scanner #(
  parameter int NUM_CH  = 128,
  parameter int CLK_DIV = 4
) (
  input logic                   clk,
  input logic                   reset,
  spi_channel_scanner_if.master bus
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]     LAST_IDX = 7'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_DONE_CH
  } state_t;

  state_t           r_state;
  logic [6:0]       r_idx;
  logic [6:0]       r_cmd;
  logic [15:0]      r_rx;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_half;
  logic             r_cs_n;
  logic             r_sclk;
  logic             r_mosi;
  logic [15:0]      r_sample_data;
  logic [6:0]       r_sample_index;
  logic             r_valid;
  logic             r_done;
  logic             r_busy;
  logic             w_div_end;

  assign w_div_end = (r_div == DIV_LAST);

  assign bus.Index_number = r_idx;
  assign bus.spi_cs_n     = r_cs_n;
  assign bus.spi_sclk     = r_sclk;
  assign bus.spi_mosi     = r_mosi;
  assign bus.sample_data  = r_sample_data;
  assign bus.sample_index = r_sample_index;
  assign bus.sample_valid = r_valid;
  assign bus.scan_done    = r_done;
  assign bus.busy         = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_cmd          <= '0;
      r_rx           <= '0;
      r_div          <= '0;
      r_half         <= '0;
      r_cs_n         <= 1'b1;
      r_sclk         <= 1'b0;
      r_mosi         <= 1'b0;
      r_sample_data  <= '0;
      r_sample_index <= '0;
      r_valid        <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // Read flag goes out first on MOSI; only the 7 channel bits remain to shift.
          r_cmd   <= bus.Index_number_remapped;
          r_mosi  <= 1'b1;
          r_cs_n  <= 1'b0;
          r_div   <= '0;
          r_state <= S_CS_SETUP;
        end
        S_CS_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_half  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              // Rising edges 9..24 carry the sample; the first 8 overlap the command.
              if (r_half >= 6'd16) r_rx <= {r_rx[14:0], bus.spi_miso};
            end else begin
              r_mosi <= r_cmd[6];
              r_cmd  <= {r_cmd[5:0], 1'b0};
            end
            if (r_half == 6'd47) r_state <= S_CS_HOLD;
            else                 r_half  <= r_half + 6'd1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_CS_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_cs_n  <= 1'b1;
            r_state <= S_DONE_CH;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE_CH: begin
          r_sample_data  <= r_rx;
          r_sample_index <= r_idx;
          r_valid        <= 1'b1;
          if (r_idx == LAST_IDX) begin
            r_done <= 1'b1;
            r_idx  <= '0;
            if (bus.continuous) begin
              r_state <= S_LOOKUP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_idx   <= r_idx + 7'd1;
            r_state <= S_LOOKUP;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
